reaction_session_ctrl: RTL and testbench



---
 rtl/reaction_session_ctrl_pkg.sv | 22 ++
 rtl/reaction_session_ctrl_ms_downcounter.sv | 33 +++
 rtl/reaction_session_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_reaction_session_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/reaction_session_ctrl_pkg.sv
// Shared encodings and constants for the reaction-timer session controller.
package reaction_session_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LIGHTS = 3'd1,
        HOLD   = 3'd2,
        GO     = 3'd3,
        RESULT = 3'd4,
        FAULT  = 3'd5,
        DONE   = 3'd6
    } state_t;

    localparam logic [9:0] FAULT_PATTERN  = 10'h155;
    localparam logic [9:0] ALL_ON         = 10'h3FF;
    localparam int         MAX_MS_DEFAULT = 9999;

    function automatic logic [13:0] sat_inc(input logic [13:0] v, input logic [13:0] lim);
        return (v >= lim) ? lim : v + 14'd1;
    endfunction

endpackage

// File: rtl/reaction_session_ctrl_ms_downcounter.sv
// 12-bit loadable millisecond down-counter; holds at zero and flags it.
module ms_downcounter (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        load,
    input  logic [11:0] load_val,
    output logic        zero
);

    logic [11:0] cnt_q;
    logic [11:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (tick && (cnt_q != 12'd0)) begin
            cnt_d = cnt_q - 12'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 12'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == 12'd0);

endmodule

// File: rtl/reaction_session_ctrl.sv
// Multi-round reaction test sequencer: light-up, random hold, ms timing,
// false-start detection and best/average bookkeeping.
module reaction_session_ctrl
    import reaction_session_ctrl_pkg::*;
#(
    parameter int N_ROUNDS      = 4,
    parameter int LIGHT_STEP_MS = 500,
    parameter int MIN_HOLD_MS   = 1000,
    parameter int RESULT_MS     = 2000,
    parameter int MAX_MS        = MAX_MS_DEFAULT
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        tick_ms,
    input  logic        start,
    input  logic        react,
    input  logic [13:0] prbs,
    output logic [9:0]  leds,
    output logic [13:0] disp_value,
    output logic [2:0]  round_idx,
    output logic        false_start,
    output logic        done
);

    // Intervals are loaded one short because expiry is taken on the tick seen at zero.
    localparam int          AVG_SH    = $clog2(N_ROUNDS);
    localparam logic [11:0] STEP_LD   = 12'(LIGHT_STEP_MS - 1);
    localparam logic [11:0] RES_LD    = 12'(RESULT_MS - 1);
    localparam logic [11:0] HOLD_BASE = 12'(MIN_HOLD_MS - 1);
    localparam logic [13:0] MAX_V     = 14'(MAX_MS);
    localparam logic [2:0]  LAST_RND  = 3'(N_ROUNDS - 1);

    state_t      state_q, state_d;
    logic [9:0]  leds_q, leds_d;
    logic [13:0] disp_q, disp_d;
    logic [2:0]  round_q, round_d;
    logic        fs_q, fs_d;
    logic        done_q, done_d;
    logic [13:0] best_q, best_d;
    logic [16:0] sum_q, sum_d;
    logic [13:0] count_q, count_d;
    logic        sel_q, sel_d;

    logic        ld;
    logic [11:0] ld_val;
    logic        tmr_zero;
    logic        expire;
    logic        new_sess;
    logic        record;
    logic        prbs_unused;

    assign prbs_unused = ^prbs[13:11];
    assign expire      = tick_ms & tmr_zero;

    ms_downcounter u_tmr (
        .clk      (CLOCK_50),
        .rst      (reset),
        .tick     (tick_ms),
        .load     (ld),
        .load_val (ld_val),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        leds_d   = leds_q;
        disp_d   = disp_q;
        round_d  = round_q;
        best_d   = best_q;
        sum_d    = sum_q;
        count_d  = count_q;
        sel_d    = sel_q;
        ld       = 1'b0;
        ld_val   = STEP_LD;
        new_sess = 1'b0;
        record   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) new_sess = 1'b1;
            end
            LIGHTS: begin
                if (react) begin
                    state_d = FAULT;
                    leds_d  = FAULT_PATTERN;
                    disp_d  = 14'd0;
                end else if (expire) begin
                    leds_d = {leds_q[8:0], 1'b1};
                    ld     = 1'b1;
                    if (leds_d == ALL_ON) begin
                        state_d = HOLD;
                        ld_val  = HOLD_BASE + {1'b0, prbs[10:0]};
                    end
                end
            end
            HOLD: begin
                if (react) begin
                    state_d = FAULT;
                    leds_d  = FAULT_PATTERN;
                    disp_d  = 14'd0;
                end else if (expire) begin
                    state_d = GO;
                    leds_d  = 10'd0;
                    count_d = 14'd0;
                    disp_d  = 14'd0;
                end
            end
            GO: begin
                // A response in a tick cycle keeps the pre-tick count.
                if (react) begin
                    record = 1'b1;
                end else if (tick_ms) begin
                    count_d = sat_inc(count_q, MAX_V);
                    disp_d  = count_d;
                    if (count_d == MAX_V) record = 1'b1;
                end
            end
            RESULT: begin
                if (expire) begin
                    leds_d = 10'd0;
                    if (round_q == LAST_RND) begin
                        state_d = DONE;
                        disp_d  = best_q;
                        sel_d   = 1'b0;
                    end else begin
                        state_d = LIGHTS;
                        round_d = round_q + 3'd1;
                        disp_d  = 14'd0;
                        ld      = 1'b1;
                    end
                end
            end
            FAULT: begin
                if (start) begin
                    state_d = LIGHTS;
                    leds_d  = 10'd0;
                    disp_d  = 14'd0;
                    ld      = 1'b1;
                end
            end
            DONE: begin
                if (start) begin
                    new_sess = 1'b1;
                end else if (react) begin
                    sel_d  = ~sel_q;
                    disp_d = sel_d ? 14'(sum_q >> AVG_SH) : best_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (record) begin
            state_d = RESULT;
            disp_d  = count_d;
            sum_d   = sum_q + {3'b000, count_d};
            if (count_d < best_q) best_d = count_d;
            ld      = 1'b1;
            ld_val  = RES_LD;
        end

        if (new_sess) begin
            state_d = LIGHTS;
            leds_d  = 10'd0;
            disp_d  = 14'd0;
            round_d = 3'd0;
            sum_d   = 17'd0;
            best_d  = MAX_V;
            sel_d   = 1'b0;
            ld      = 1'b1;
        end

        fs_d   = (state_d == FAULT);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            leds_q  <= 10'd0;
            disp_q  <= 14'd0;
            round_q <= 3'd0;
            fs_q    <= 1'b0;
            done_q  <= 1'b0;
            best_q  <= MAX_V;
            sum_q   <= 17'd0;
            count_q <= 14'd0;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            leds_q  <= leds_d;
            disp_q  <= disp_d;
            round_q <= round_d;
            fs_q    <= fs_d;
            done_q  <= done_d;
            best_q  <= best_d;
            sum_q   <= sum_d;
            count_q <= count_d;
            sel_q   <= sel_d;
        end
    end

    assign leds        = leds_q;
    assign disp_value  = disp_q;
    assign round_idx   = round_q;
    assign false_start = fs_q;
    assign done        = done_q;

endmodule

// File: tb/tb_reaction_session_ctrl.sv
// Directed bench for reaction_session_ctrl with hand-computed expectations.
module tb_reaction_session_ctrl;

    logic        CLOCK_50 = 1'b0;
    logic        reset    = 1'b1;
    logic        tick_ms  = 1'b0;
    logic        start    = 1'b0;
    logic        react    = 1'b0;
    logic [13:0] prbs     = 14'h0003;
    logic [9:0]  leds;
    logic [13:0] disp_value;
    logic [2:0]  round_idx;
    logic        false_start;
    logic        done;

    int nvec     = 0;
    int nerr     = 0;
    int ph       = 0;
    int tick_per = 4;

    reaction_session_ctrl #(
        .N_ROUNDS      (4),
        .LIGHT_STEP_MS (2),
        .MIN_HOLD_MS   (4),
        .RESULT_MS     (3),
        .MAX_MS        (9999)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .tick_ms     (tick_ms),
        .start       (start),
        .react       (react),
        .prbs        (prbs),
        .leds        (leds),
        .disp_value  (disp_value),
        .round_idx   (round_idx),
        .false_start (false_start),
        .done        (done)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic s, input logic r);
        start   = s;
        react   = r;
        tick_ms = (ph == tick_per - 1);
        @(posedge CLOCK_50);
        #1;
        ph      = (ph + 1) % tick_per;
        start   = 1'b0;
        react   = 1'b0;
        tick_ms = 1'b0;
    endtask

    task automatic run_ticks(input int n);
        int k = 0;
        while (k < n) begin
            if (ph == tick_per - 1) k++;
            cyc(1'b0, 1'b0);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_leds"}, 32'(leds), 32'd0);
        chk({tag, "_disp"}, 32'(disp_value), 32'd0);
        chk({tag, "_round"}, 32'(round_idx), 32'd0);
        chk({tag, "_fs"}, 32'(false_start), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
    endtask

    int times [4] = '{40, 25, 60, 35};

    initial begin
        // reset state
        repeat (3) @(posedge CLOCK_50);
        #1;
        chk_all_zero("in_reset");
        reset = 1'b0;
        cyc(1'b0, 1'b0);
        chk_all_zero("after_reset");
        run_ticks(3);
        cyc(1'b0, 1'b1);
        chk("idle_react_ignored_fs", 32'(false_start), 32'd0);
        chk("idle_leds", 32'(leds), 32'd0);

        // scenario 1: light-up, hold, live count
        cyc(1'b1, 1'b0);
        chk("start_leds", 32'(leds), 32'd0);
        run_ticks(2);  chk("lights_1", 32'(leds), 32'h001);
        run_ticks(2);  chk("lights_3", 32'(leds), 32'h003);
        run_ticks(15); chk("lights_1ff", 32'(leds), 32'h1FF);
        run_ticks(1);  chk("lights_3ff", 32'(leds), 32'h3FF);
        run_ticks(6);  chk("hold_6", 32'(leds), 32'h3FF);
        run_ticks(1);  chk("go_leds", 32'(leds), 32'd0);
        chk("go_disp0", 32'(disp_value), 32'd0);
        run_ticks(1);  chk("go_disp1", 32'(disp_value), 32'd1);
        run_ticks(1);  chk("go_disp2", 32'(disp_value), 32'd2);
        run_ticks(1);  chk("go_disp3", 32'(disp_value), 32'd3);
        run_ticks(34); chk("go_disp37", 32'(disp_value), 32'd37);

        // scenario 2: result display and next round
        cyc(1'b0, 1'b1);
        chk("result_disp", 32'(disp_value), 32'd37);
        run_ticks(2);
        chk("result_hold_disp", 32'(disp_value), 32'd37);
        chk("result_hold_round", 32'(round_idx), 32'd0);
        run_ticks(1);
        chk("next_round", 32'(round_idx), 32'd1);
        chk("next_leds", 32'(leds), 32'd0);
        run_ticks(2);
        chk("next_lights_1", 32'(leds), 32'h001);

        // scenario 3: false start in HOLD
        run_ticks(18);
        chk("r1_hold_leds", 32'(leds), 32'h3FF);
        run_ticks(3);
        cyc(1'b0, 1'b1);
        chk("fault_fs", 32'(false_start), 32'd1);
        chk("fault_leds", 32'(leds), 32'h155);
        chk("fault_round", 32'(round_idx), 32'd1);
        chk("fault_disp", 32'(disp_value), 32'd0);
        run_ticks(5);
        chk("fault_sticky", 32'(false_start), 32'd1);
        cyc(1'b1, 1'b0);
        chk("fault_exit_fs", 32'(false_start), 32'd0);
        chk("fault_exit_leds", 32'(leds), 32'd0);
        chk("fault_exit_round", 32'(round_idx), 32'd1);
        run_ticks(2);
        chk("fault_relight", 32'(leds), 32'h001);

        // scenario 4: full fresh session
        reset = 1'b1;
        cyc(1'b0, 1'b0);
        reset = 1'b0;
        cyc(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            run_ticks(27);
            chk("sess_go_leds", 32'(leds), 32'd0);
            chk("sess_round", 32'(round_idx), 32'(i));
            run_ticks(times[i]);
            chk("sess_live", 32'(disp_value), 32'(times[i]));
            cyc(1'b0, 1'b1);
            chk("sess_result", 32'(disp_value), 32'(times[i]));
            run_ticks(3);
        end
        chk("done_flag", 32'(done), 32'd1);
        chk("done_best", 32'(disp_value), 32'd25);
        chk("done_leds", 32'(leds), 32'd0);
        chk("done_round", 32'(round_idx), 32'd3);
        cyc(1'b0, 1'b1);
        chk("done_avg", 32'(disp_value), 32'd40);
        chk("done_still", 32'(done), 32'd1);
        cyc(1'b0, 1'b1);
        chk("done_best_again", 32'(disp_value), 32'd25);

        // scenario 5: timeout saturation, then react coincident with last tick
        cyc(1'b1, 1'b0);
        chk("restart_done", 32'(done), 32'd0);
        chk("restart_round", 32'(round_idx), 32'd0);
        run_ticks(27);
        run_ticks(9998);
        chk("sat_9998", 32'(disp_value), 32'd9998);
        run_ticks(1);
        chk("sat_9999", 32'(disp_value), 32'd9999);
        run_ticks(2);
        chk("sat_result", 32'(disp_value), 32'd9999);
        chk("sat_result_round", 32'(round_idx), 32'd0);
        run_ticks(1);
        chk("sat_next_round", 32'(round_idx), 32'd1);

        tick_per = 1;
        ph       = 0;
        run_ticks(27);
        run_ticks(9998);
        chk("coin_pre", 32'(disp_value), 32'd9998);
        cyc(1'b0, 1'b1);
        chk("coin_result", 32'(disp_value), 32'd9998);
        run_ticks(2);
        chk("coin_held", 32'(disp_value), 32'd9998);
        chk("coin_round", 32'(round_idx), 32'd1);
        run_ticks(1);
        chk("coin_next_round", 32'(round_idx), 32'd2);
        tick_per = 4;
        ph       = 0;

        // scenario 6: start ignored in GO and RESULT
        run_ticks(27);
        run_ticks(5);
        chk("go5", 32'(disp_value), 32'd5);
        cyc(1'b1, 1'b0);
        chk("go_start_disp", 32'(disp_value), 32'd5);
        chk("go_start_leds", 32'(leds), 32'd0);
        run_ticks(1);
        chk("go_still_counting", 32'(disp_value), 32'd6);
        cyc(1'b0, 1'b1);
        chk("r2_result", 32'(disp_value), 32'd6);
        cyc(1'b1, 1'b0);
        chk("result_start_disp", 32'(disp_value), 32'd6);
        run_ticks(2);
        chk("result_start_round", 32'(round_idx), 32'd2);
        chk("result_start_held", 32'(disp_value), 32'd6);
        run_ticks(1);
        chk("r3_round", 32'(round_idx), 32'd3);

        // asynchronous reset between edges mid-GO
        run_ticks(27);
        run_ticks(10);
        chk("r3_go10", 32'(disp_value), 32'd10);
        #3 reset = 1'b1;
        #1;
        chk_all_zero("async_rst");
        cyc(1'b0, 1'b0);
        reset = 1'b0;
        run_ticks(4);
        chk_all_zero("post_rst_idle");
        cyc(1'b1, 1'b0);
        run_ticks(2);
        chk("post_rst_lights", 32'(leds), 32'h001);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
